// File: rtl/set_false_path_pkg.sv
// set_false_path_pkg: shared state encoding and default sizes for the four-phase CDC responder.
package set_false_path_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DELIVER  = 2'd1,
    ACK_HIGH = 2'd2
  } state_t;
  localparam int DEF_WIDTH       = 8;
  localparam int DEF_SYNC_STAGES = 2;
endpackage

// File: rtl/cdc_sync_bit.sv
// cdc_sync_bit: multi-flop level synchronizer for a single asynchronous bit.
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk2,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] r_sync;
  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) r_sync <= '0;
    else        r_sync <= {r_sync[STAGES-2:0], d};
  assign q = r_sync[STAGES-1];
endmodule

// File: rtl/set_false_path_cdc_responder.sv
// set_false_path_cdc_responder: receive side of a four-phase req/ack crossing, delivering each word
// to a valid/ready consumer before acknowledging. Only req is synchronized; data rides on the handshake.
module set_false_path_cdc_responder
  import set_false_path_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = 8
) (
  input  logic             clk2,
  input  logic             rst_n,
  input  logic             req_async,
  input  logic [WIDTH-1:0] data_async,
  output logic             ack,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] xfer_count,
  output logic             protocol_err
);
  logic             w_req_sync;
  state_t           r_state, w_state;
  logic             r_ack, w_ack, r_valid, w_valid, r_err, w_err;
  logic [WIDTH-1:0] r_data, w_data;
  logic [CNT_W-1:0] r_cnt, w_cnt;

  cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_req_sync (
    .clk2  (clk2),
    .rst_n (rst_n),
    .d     (req_async),
    .q     (w_req_sync)
  );

  // data_async is only sampled once the synchronized req proves it has settled
  always_comb begin
    w_state = r_state;
    w_ack   = r_ack;
    w_valid = r_valid;
    w_err   = r_err;
    w_data  = r_data;
    w_cnt   = r_cnt;
    case (r_state)
      IDLE:
        if (w_req_sync) begin
          w_data  = data_async;
          w_valid = 1'b1;
          w_state = DELIVER;
        end
      DELIVER:
        if (!w_req_sync) begin
          w_err   = 1'b1;
          w_valid = 1'b0;
          w_state = IDLE;
        end else if (out_ready) begin
          w_valid = 1'b0;
          w_ack   = 1'b1;
          w_cnt   = r_cnt + 1'b1;
          w_state = ACK_HIGH;
        end
      ACK_HIGH:
        if (!w_req_sync) begin
          w_ack   = 1'b0;
          w_state = IDLE;
        end
      default: w_state = IDLE;
    endcase
  end

  always_ff @(posedge clk2 or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_data  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state;
      r_ack   <= w_ack;
      r_valid <= w_valid;
      r_err   <= w_err;
      r_data  <= w_data;
      r_cnt   <= w_cnt;
    end

  assign ack          = r_ack;
  assign out_data     = r_data;
  assign out_valid    = r_valid;
  assign xfer_count   = r_cnt;
  assign protocol_err = r_err;
endmodule

// File: tb/tb_set_false_path_cdc_responder.sv
// tb_set_false_path_cdc_responder: directed handshake scenarios plus 300 randomized transfers,
// checked against an in-order word scoreboard and a wrapping transfer-count model.
module tb_set_false_path_cdc_responder;
  localparam int S = 2;
  logic       clk2 = 1'b0;
  logic       rst_n;
  logic       req_async;
  logic [7:0] data_async;
  logic       ack;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] xfer_count;
  logic       protocol_err;
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_cnt = 8'd0;

  set_false_path_cdc_responder #(.WIDTH(8), .SYNC_STAGES(S), .CNT_W(8)) dut (
    .clk2         (clk2),
    .rst_n        (rst_n),
    .req_async    (req_async),
    .data_async   (data_async),
    .ack          (ack),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .xfer_count   (xfer_count),
    .protocol_err (protocol_err)
  );

  always #5 clk2 = ~clk2;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk2);
    #1;
  endtask

  // inputs change just after posedge, so valid&ready seen here is accepted on the next edge
  always @(negedge clk2)
    if (rst_n && out_valid && out_ready)
      check("sb_word", 32'(out_data), exp_q.size() != 0 ? 32'(exp_q.pop_front()) : 32'hDEAD_BEEF);

  task automatic wait_ack(input string tag, input logic v, input bit rnd);
    for (int n = 0; n < 200 && ack !== v; n++) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    check(tag, 32'(ack), 32'(v));
  endtask

  task automatic wait_valid(input string tag);
    for (int n = 0; n < 50 && out_valid !== 1'b1; n++) tick();
    check(tag, 32'(out_valid), 1);
  endtask

  task automatic send(input logic [7:0] d, input bit rnd);
    exp_q.push_back(d);
    data_async = d;
    req_async  = 1'b1;
    if (!rnd) out_ready = 1'b1;
    wait_ack("send_ack_rise", 1'b1, rnd);
    exp_cnt++;
    check("send_cnt", 32'(xfer_count), 32'(exp_cnt));
    req_async = 1'b0;
    wait_ack("send_ack_fall", 1'b0, rnd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req_async = 1'b0; data_async = 8'h00; out_ready = 1'b0;
    #13;
    check("rst_ack", 32'(ack), 0);
    check("rst_valid", 32'(out_valid), 0);
    check("rst_data", 32'(out_data), 0);
    check("rst_cnt", 32'(xfer_count), 0);
    check("rst_err", 32'(protocol_err), 0);
    tick();
    rst_n = 1'b1;
    tick();
    // single transfer with exact edge timing
    data_async = 8'hA5; req_async = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'hA5);
    for (int i = 0; i < S; i++) begin
      tick();
      check("t1_no_valid", 32'(out_valid), 0);
    end
    tick();
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'h A5);
    tick();
    exp_cnt++;
    check("t1_ack", 32'(ack), 1);
    check("t1_cnt", 32'(xfer_count), 32'(exp_cnt));
    check("t1_valid_off", 32'(out_valid), 0);
    req_async = 1'b0;
    for (int i = 0; i < S; i++) begin
      tick();
      check("t1_ack_hold", 32'(ack), 1);
    end
    tick();
    check("t1_ack_fall", 32'(ack), 0);
    // backpressure
    out_ready = 1'b0; data_async = 8'h3C; req_async = 1'b1;
    exp_q.push_back(8'h3C);
    wait_valid("bp_valid");
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 32'(out_valid), 1);
      check("bp_hold_data", 32'(out_data), 32'h3C);
      check("bp_no_ack", 32'(ack), 0);
    end
    out_ready = 1'b1;
    tick();
    exp_cnt++;
    check("bp_ack", 32'(ack), 1);
    check("bp_cnt", 32'(xfer_count), 32'(exp_cnt));
    req_async = 1'b0;
    wait_ack("bp_ack_fall", 1'b0, 1'b0);
    // abort: req withdrawn while the word is still undelivered
    out_ready = 1'b0; data_async = 8'h5A; req_async = 1'b1;
    wait_valid("ab_valid");
    req_async = 1'b0;
    for (int n = 0; n < 50 && out_valid === 1'b1; n++) tick();
    check("ab_valid_off", 32'(out_valid), 0);
    check("ab_err", 32'(protocol_err), 1);
    check("ab_cnt", 32'(xfer_count), 32'(exp_cnt));
    for (int i = 0; i < S + 2; i++) begin
      tick();
      check("ab_no_ack", 32'(ack), 0);
    end
    send(8'hC3, 1'b0);
    check("ab_err_sticky", 32'(protocol_err), 1);
    // data changes before capture; only the capture-edge value counts
    exp_q.push_back(8'h22);
    out_ready = 1'b1; data_async = 8'h11; req_async = 1'b1;
    tick();
    data_async = 8'h22;
    wait_ack("ds_ack", 1'b1, 1'b0);
    exp_cnt++;
    check("ds_data", 32'(out_data), 32'h22);
    check("ds_cnt", 32'(xfer_count), 32'(exp_cnt));
    req_async = 1'b0;
    wait_ack("ds_ack_fall", 1'b0, 1'b0);
    // asynchronous reset while in ACK_HIGH
    data_async = 8'h77; req_async = 1'b1; out_ready = 1'b1;
    exp_q.push_back(8'h77);
    wait_ack("rm_ack", 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    exp_cnt = 8'd0;
    check("rm_ack_clr", 32'(ack), 0);
    check("rm_valid_clr", 32'(out_valid), 0);
    check("rm_cnt_clr", 32'(xfer_count), 0);
    check("rm_err_clr", 32'(protocol_err), 0);
    tick();
    tick();
    rst_n = 1'b1;
    exp_q.push_back(8'h77);
    for (int i = 0; i < S; i++) begin
      tick();
      check("rm_no_valid", 32'(out_valid), 0);
    end
    tick();
    check("rm_recapture", 32'(out_valid), 1);
    check("rm_data", 32'(out_data), 32'h77);
    tick();
    exp_cnt++;
    check("rm_cnt", 32'(xfer_count), 32'(exp_cnt));
    req_async = 1'b0;
    wait_ack("rm_ack_fall", 1'b0, 1'b0);
    // 300 back-to-back transfers with random backpressure
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_cnt = 8'd0;
    for (int i = 0; i < 300; i++) begin
      data_async = 8'($urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) tick();
      send(8'(i + 1), 1'b1);
    end
    check("b2b_cnt_44", 32'(xfer_count), 44);
    check("b2b_cnt_model", 32'(xfer_count), 32'(exp_cnt));
    check("b2b_err", 32'(protocol_err), 0);
    tick();
    check("sb_drained", 32'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
